// File: rtl/counter_op_arbiter_if.sv
// Requester-side bundle for counter_op_arbiter: per-requester request level,
// 2-bit op code, load value, and the one-cycle grant pulse returned by the arbiter.
interface counter_op_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] load_data;
  logic [N_REQ-1:0]       gnt;

  // Requesters drive req/op/load_data and watch gnt
  modport master (
    output req,
    output op,
    output load_data,
    input  gnt
  );

  // The arbiter samples req/op/load_data and drives gnt
  modport slave (
    input  req,
    input  op,
    input  load_data,
    output gnt
  );
endinterface

// File: rtl/counter_op_arbiter.sv
// counter_op_arbiter: one WIDTH-bit counter shared by N_REQ requesters and a
// prescaled autocount tick. A round-robin arbiter grants at most one op per
// cycle (inc / dec / clear / load); host ops always beat the pending tick.
// Wrap, compare-match and dropped-tick events come out as one-cycle pulses.
module counter_op_arbiter #(
  parameter int                    N_REQ      = 4,
  parameter int                    WIDTH      = 8,
  parameter int                    DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0]  DIV_RELOAD = 24'h100000
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  counter_op_arbiter_if.slave  bus,
  input  logic                 autocount_en,
  input  logic                 hold,
  input  logic [WIDTH-1:0]     match_value,
  output logic [WIDTH-1:0]     count,
  output logic                 match_pulse,
  output logic                 wrap_pulse,
  output logic                 tick_drop
);

  localparam int               PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]   N_REQ_W = (PTR_W + 1)'(N_REQ);

  localparam logic [1:0] OP_INC   = 2'b00;
  localparam logic [1:0] OP_DEC   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]     count_reg;
  logic [N_REQ-1:0]     gnt_reg;
  logic [PTR_W-1:0]     ptr_reg;
  logic [DIV_WIDTH-1:0] presc_reg;
  logic                 tick_pending_reg;
  logic                 match_pulse_reg;
  logic                 wrap_pulse_reg;
  logic                 tick_drop_reg;

  // ---------------------------------------------------------------------------
  // Per-requester views of the packed op / load_data buses
  // ---------------------------------------------------------------------------
  logic [1:0]       req_op   [N_REQ];
  logic [WIDTH-1:0] req_data [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_op[gi]   = bus.op[2*gi +: 2];
    assign req_data[gi] = bus.load_data[WIDTH*gi +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // Last cycle's winner sits out one cycle so nobody can win back-to-back.
  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] ptr_next;
  logic [N_REQ-1:0] gnt_next;

  assign eligible = bus.req & ~gnt_reg;

  // Round-robin search upward from the pointer. The loop runs from the far
  // end back toward the pointer so the closest eligible index is written last.
  always_comb begin
    logic [PTR_W:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (PTR_W + 1)'(k);
      if (cand >= N_REQ_W) begin
        cand = cand - N_REQ_W;
      end
      if (eligible[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next pointer and one-hot grant derived from the winner
  always_comb begin
    ptr_next = ptr_reg;
    gnt_next = '0;
    if (win_found) begin
      gnt_next = N_REQ'(1) << win_idx;
      if (win_idx == PTR_W'(N_REQ - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = win_idx + 1'b1;
      end
    end
  end

  // Grant pulse and round-robin pointer registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      gnt_reg <= '0;
      ptr_reg <= '0;
    end else begin
      gnt_reg <= gnt_next;
      ptr_reg <= ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and pending autocount tick
  // ---------------------------------------------------------------------------
  logic presc_tick;
  logic auto_write;

  // hold freezes the prescaler, so no tick can be generated while it is high.
  assign presc_tick = !hold && (presc_reg == '0);

  // A pending tick only lands in a cycle with no eligible host request.
  assign auto_write = autocount_en && tick_pending_reg && !win_found && !hold;

  // Down-counter that reloads at zero and emits one tick per period
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      presc_reg <= DIV_RELOAD;
    end else if (!hold) begin
      if (presc_reg == '0) begin
        presc_reg <= DIV_RELOAD;
      end else begin
        presc_reg <= presc_reg - 1'b1;
      end
    end
  end

  // Pending-tick flag and dropped-tick pulse. If the pending tick is consumed
  // on the same edge a new one arrives, the new one takes its place and
  // nothing is lost, so no drop is reported in that case.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tick_pending_reg <= 1'b0;
      tick_drop_reg    <= 1'b0;
    end else begin
      tick_drop_reg <= autocount_en && presc_tick && tick_pending_reg && !auto_write;
      if (!autocount_en) begin
        tick_pending_reg <= 1'b0;
      end else if (presc_tick) begin
        tick_pending_reg <= 1'b1;
      end else if (auto_write) begin
        tick_pending_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter update
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] host_result;
  logic             host_wrap;
  logic             write_en;
  logic [WIDTH-1:0] write_val;
  logic             wrap_evt;

  // Result of the granted requester's op; only inc/dec can wrap
  always_comb begin
    host_result = count_reg;
    host_wrap   = 1'b0;
    case (req_op[win_idx])
      OP_INC: begin
        host_result = count_reg + 1'b1;
        host_wrap   = &count_reg;
      end
      OP_DEC: begin
        host_result = count_reg - 1'b1;
        host_wrap   = ~|count_reg;
      end
      OP_CLEAR: begin
        host_result = '0;
      end
      default: begin
        host_result = req_data[win_idx];
      end
    endcase
  end

  // Single write port: host grant first, otherwise the pending autocount inc
  always_comb begin
    write_en  = win_found || auto_write;
    write_val = count_reg + 1'b1;
    wrap_evt  = &count_reg;
    if (win_found) begin
      write_val = host_result;
      wrap_evt  = host_wrap;
    end
  end

  // Counter register plus wrap and match pulses tied to actual writes.
  // Match fires only on a transition into match_value, so rewriting the same
  // value or moving match_value onto the current count stays silent.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count_reg       <= '0;
      wrap_pulse_reg  <= 1'b0;
      match_pulse_reg <= 1'b0;
    end else begin
      wrap_pulse_reg  <= 1'b0;
      match_pulse_reg <= 1'b0;
      if (write_en) begin
        count_reg       <= write_val;
        wrap_pulse_reg  <= wrap_evt;
        match_pulse_reg <= (write_val == match_value) && (count_reg != write_val);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.gnt     = gnt_reg;
  assign count       = count_reg;
  assign match_pulse = match_pulse_reg;
  assign wrap_pulse  = wrap_pulse_reg;
  assign tick_drop   = tick_drop_reg;

endmodule

// File: tb/tb_counter_op_arbiter.sv
// Directed bench for counter_op_arbiter with a short prescaler period (4 cycles).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_counter_op_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic             sys_clk;
  logic             reset;
  logic             autocount_en;
  logic             hold;
  logic [WIDTH-1:0] match_value;
  logic [WIDTH-1:0] count;
  logic             match_pulse;
  logic             wrap_pulse;
  logic             tick_drop;

  int tests;
  int failed;

  counter_op_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  counter_op_arbiter #(
    .N_REQ      (N_REQ),
    .WIDTH      (WIDTH),
    .DIV_WIDTH  (24),
    .DIV_RELOAD (24'd3)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .bus          (bus),
    .autocount_en (autocount_en),
    .hold         (hold),
    .match_value  (match_value),
    .count        (count),
    .match_pulse  (match_pulse),
    .wrap_pulse   (wrap_pulse),
    .tick_drop    (tick_drop)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests         = 0;
    failed        = 0;
    reset         = 1'b1;
    autocount_en  = 1'b0;
    hold          = 1'b0;
    match_value   = 8'hAA;
    bus.req       = '0;
    bus.op        = '0;
    bus.load_data = '0;

    // Reset state
    step();
    step();
    check("rst_count", count, 8'h00);
    check("rst_gnt", bus.gnt, 4'b0000);
    check("rst_pulses", {match_pulse, wrap_pulse, tick_drop}, 3'b000);

    // 1: single requester holding inc -> grants on alternate cycles
    reset   = 1'b0;
    bus.req = 4'b0001;
    bus.op  = 8'h00;
    step();
    check("t1_gnt_a", bus.gnt, 4'b0001);
    check("t1_cnt_a", count, 8'h01);
    step();
    check("t1_gnt_masked", bus.gnt, 4'b0000);
    check("t1_cnt_hold", count, 8'h01);
    step();
    check("t1_gnt_b", bus.gnt, 4'b0001);
    check("t1_cnt_b", count, 8'h02);
    bus.req = 4'b0000;
    step();
    check("t1_gnt_idle", bus.gnt, 4'b0000);

    // 2: all four requesting from pointer 0 -> order 0,1,2,3,0
    reset = 1'b1;
    step();
    reset   = 1'b0;
    bus.req = 4'b1111;
    bus.op  = 8'h00;
    step();
    check("t2_gnt0", bus.gnt, 4'b0001);
    check("t2_cnt0", count, 8'h01);
    step();
    check("t2_gnt1", bus.gnt, 4'b0010);
    check("t2_cnt1", count, 8'h02);
    step();
    check("t2_gnt2", bus.gnt, 4'b0100);
    check("t2_cnt2", count, 8'h03);
    step();
    check("t2_gnt3", bus.gnt, 4'b1000);
    check("t2_cnt3", count, 8'h04);
    step();
    check("t2_gnt4", bus.gnt, 4'b0001);
    check("t2_cnt4", count, 8'h05);
    bus.req = 4'b0000;
    step();
    check("t2_idle", {bus.gnt, count}, {4'b0000, 8'h05});

    // 3: load FF, inc wraps to 00, dec wraps to FF
    bus.req       = 4'b0100;
    bus.op        = 8'h30;
    bus.load_data = 32'h00FF_0000;
    step();
    check("t3_load_gnt", bus.gnt, 4'b0100);
    check("t3_load_cnt", count, 8'hFF);
    check("t3_load_nowrap", wrap_pulse, 1'b0);
    bus.req = 4'b0010;
    bus.op  = 8'h00;
    step();
    check("t3_inc_gnt", bus.gnt, 4'b0010);
    check("t3_inc_cnt", count, 8'h00);
    check("t3_inc_wrap", wrap_pulse, 1'b1);
    bus.req = 4'b0001;
    bus.op  = 8'h01;
    step();
    check("t3_dec_gnt", bus.gnt, 4'b0001);
    check("t3_dec_cnt", count, 8'hFF);
    check("t3_dec_wrap", wrap_pulse, 1'b1);
    bus.req = 4'b0000;
    step();
    check("t3_wrap_clear", {wrap_pulse, count}, {1'b0, 8'hFF});

    // 4: match on a transition into 05 only
    match_value   = 8'h05;
    bus.req       = 4'b0001;
    bus.op        = 8'h03;
    bus.load_data = 32'h0000_0004;
    step();
    check("t4_load04", {bus.gnt, count}, {4'b0001, 8'h04});
    check("t4_load04_nomatch", match_pulse, 1'b0);
    bus.req = 4'b1000;
    bus.op  = 8'h00;
    step();
    check("t4_inc05", {bus.gnt, count}, {4'b1000, 8'h05});
    check("t4_match", match_pulse, 1'b1);
    bus.req       = 4'b0001;
    bus.op        = 8'h03;
    bus.load_data = 32'h0000_0005;
    step();
    check("t4_reload05", {bus.gnt, count}, {4'b0001, 8'h05});
    check("t4_rewrite_nomatch", match_pulse, 1'b0);
    bus.req     = 4'b0000;
    match_value = 8'h09;
    step();
    match_value = 8'h05;
    step();
    check("t4_cmpchg_nomatch", match_pulse, 1'b0);

    // 5: autocount every 4 cycles, then deferred tick and drop under load
    reset       = 1'b1;
    match_value = 8'hAA;
    step();
    reset        = 1'b0;
    autocount_en = 1'b1;
    repeat (4) step();
    check("t5_pre_tick", count, 8'h00);
    step();
    check("t5_auto1", count, 8'h01);
    check("t5_auto_nognt", bus.gnt, 4'b0000);
    repeat (3) step();
    check("t5_between", count, 8'h01);
    step();
    check("t5_auto2", count, 8'h02);
    bus.req = 4'b0011;
    bus.op  = 8'h00;
    step();
    check("t5_busy_a", {bus.gnt, count}, {4'b0001, 8'h03});
    step();
    check("t5_busy_b", {bus.gnt, count}, {4'b0010, 8'h04});
    step();
    check("t5_tick_pend", {bus.gnt, count, tick_drop}, {4'b0001, 8'h05, 1'b0});
    repeat (3) step();
    check("t5_busy_c", count, 8'h08);
    step();
    check("t5_drop_cnt", count, 8'h09);
    check("t5_drop", tick_drop, 1'b1);
    bus.req = 4'b0000;
    step();
    check("t5_deferred", {bus.gnt, count, tick_drop}, {4'b0000, 8'h0A, 1'b0});
    step();
    check("t5_single_deferred", count, 8'h0A);

    // 6: hold freezes prescaler and tick; host ops still apply
    hold = 1'b1;
    repeat (4) step();
    check("t6_hold_a", count, 8'h0A);
    bus.req = 4'b0100;
    bus.op  = 8'h00;
    step();
    check("t6_hold_host", {bus.gnt, count}, {4'b0100, 8'h0B});
    bus.req = 4'b0000;
    repeat (5) step();
    check("t6_hold_b", count, 8'h0B);
    hold = 1'b0;
    repeat (2) step();
    check("t6_resume_wait", count, 8'h0B);
    step();
    check("t6_resume_auto", count, 8'h0C);

    // Reset during a grant cycle; held requests restart from pointer 0
    bus.req = 4'b0010;
    step();
    check("t6_pre_rst_gnt", {bus.gnt, count}, {4'b0010, 8'h0D});
    reset   = 1'b1;
    bus.req = 4'b1010;
    step();
    check("t6_rst_cnt", count, 8'h00);
    check("t6_rst_gnt", bus.gnt, 4'b0000);
    check("t6_rst_pulses", {match_pulse, wrap_pulse, tick_drop}, 3'b000);
    reset = 1'b0;
    step();
    check("t6_ptr0_gnt", bus.gnt, 4'b0010);
    check("t6_ptr0_cnt", count, 8'h01);
    bus.req      = 4'b0000;
    autocount_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
